// File: rtl/uart_result_tx_seq.sv
`default_nettype none
// ============================================================================
// Module  : uart_result_tx_seq
// Purpose : Sends one ALU result to the UART TX FIFO as decimal ASCII:
//           an optional '-', up to three digits with leading zeros
//           suppressed, then an optional CR LF. Digits come from repeated
//           subtraction, one step per cycle.
// Ports   : clk      - system clock
//           reset    - asynchronous active-high reset
//           start    - send request, accepted only while idle
//           result   - ALU result, sampled on the accepting cycle
//           tx_full  - TX FIFO full flag; stalls character output
//           wr_uart  - TX FIFO write strobe, one cycle per character
//           uart_out - character presented to the TX FIFO
//           busy     - high while converting or emitting
//           done     - one-cycle pulse after the final character
// Revision: 1.0 - initial release
// ============================================================================
module uart_result_tx_seq #(
  parameter int N        = 8,
  parameter bit SIGNED   = 1'b0,
  parameter bit SEND_EOL = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] result,
  input  logic         tx_full,
  output logic         wr_uart,
  output logic [7:0]   uart_out,
  output logic         busy,
  output logic         done
);

  localparam int W = N + 1;  // one extra bit so -128 has a positive magnitude

  localparam logic [W-1:0] C_HUNDRED = W'(100);
  localparam logic [W-1:0] C_TEN     = W'(10);
  localparam logic [7:0]   C_ASCII_0 = 8'h30;
  localparam logic [7:0]   C_MINUS   = 8'h2D;
  localparam logic [7:0]   C_CR      = 8'h0D;
  localparam logic [7:0]   C_LF      = 8'h0A;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HUND = 3'd1,
    S_TENS = 3'd2,
    S_EMIT = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t       r_state;
  state_t       w_state_next;
  logic [W-1:0] r_work;
  logic         r_neg;
  logic [1:0]   r_hund;
  logic [3:0]   r_tens;
  logic [7:0]   r_chars [0:7];
  logic [2:0]   r_last;        // index of the final character
  logic [2:0]   r_idx;         // index of the character being presented
  logic [7:0]   r_uart_out;

  logic [W-1:0] w_mag;
  logic         w_is_neg;
  logic         w_ge100;
  logic         w_ge10;
  logic         w_write;
  logic [2:0]   w_idx_next;
  logic [7:0]   w_chars [0:7];
  logic [2:0]   w_len;

  assign w_is_neg   = SIGNED && result[N-1];
  // Two's-complement negation over the sign-extended value.
  assign w_mag      = w_is_neg ? (~{1'b1, result} + {{N{1'b0}}, 1'b1})
                               : {1'b0, result};
  assign w_ge100    = (r_work >= C_HUNDRED);
  assign w_ge10     = (r_work >= C_TEN);
  assign w_write    = (r_state == S_EMIT) && !tx_full;
  assign w_idx_next = r_idx + 3'd1;
  assign uart_out   = r_uart_out;

  // Character list, only meaningful on the last TENS cycle when r_work
  // already holds the units digit.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      w_chars[i] = 8'h00;
    end
    w_len = 3'd0;
    if (r_neg) begin
      w_chars[w_len] = C_MINUS;
      w_len          = w_len + 3'd1;
    end
    if (r_hund != 2'd0) begin
      w_chars[w_len] = C_ASCII_0 + {6'd0, r_hund};
      w_len          = w_len + 3'd1;
    end
    if ((r_hund != 2'd0) || (r_tens != 4'd0)) begin
      w_chars[w_len] = C_ASCII_0 + {4'd0, r_tens};
      w_len          = w_len + 3'd1;
    end
    w_chars[w_len] = C_ASCII_0 + {4'd0, r_work[3:0]};
    w_len          = w_len + 3'd1;
    if (SEND_EOL) begin
      w_chars[w_len] = C_CR;
      w_len          = w_len + 3'd1;
      w_chars[w_len] = C_LF;
      w_len          = w_len + 3'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    wr_uart      = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_next = S_HUND;
      end
      S_HUND: begin
        busy = 1'b1;
        if (!w_ge100) w_state_next = S_TENS;
      end
      S_TENS: begin
        busy = 1'b1;
        if (!w_ge10) w_state_next = S_EMIT;
      end
      S_EMIT: begin
        busy    = 1'b1;
        wr_uart = w_write;
        if (w_write && (r_idx == r_last)) w_state_next = S_DONE;
      end
      S_DONE: begin
        done         = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_work     <= '0;
      r_neg      <= 1'b0;
      r_hund     <= 2'd0;
      r_tens     <= 4'd0;
      r_last     <= 3'd0;
      r_idx      <= 3'd0;
      r_uart_out <= 8'h00;
      for (int i = 0; i < 8; i++) begin
        r_chars[i] <= 8'h00;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_work <= w_mag;
            r_neg  <= w_is_neg;
            r_hund <= 2'd0;
            r_tens <= 4'd0;
            r_idx  <= 3'd0;
          end
        end
        S_HUND: begin
          if (w_ge100) begin
            r_work <= r_work - C_HUNDRED;
            r_hund <= r_hund + 2'd1;
          end
        end
        S_TENS: begin
          if (w_ge10) begin
            r_work <= r_work - C_TEN;
            r_tens <= r_tens + 4'd1;
          end else begin
            // Freeze the string and present its first character so the
            // first write can happen on the first EMIT cycle.
            for (int i = 0; i < 8; i++) begin
              r_chars[i] <= w_chars[i];
            end
            r_last     <= w_len - 3'd1;
            r_idx      <= 3'd0;
            r_uart_out <= w_chars[0];
          end
        end
        S_EMIT: begin
          if (w_write) begin
            r_idx <= w_idx_next;
            if (r_idx != r_last) r_uart_out <= r_chars[w_idx_next];
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_result_tx_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_result_tx_seq
// Purpose : Self-checking bench for uart_result_tx_seq. An unsigned and a
//           signed instance share all inputs; a string-level model of each
//           predicts busy/done/wr_uart/uart_out every cycle.
// Revision: 1.0 - initial release
// ============================================================================
module tb_uart_result_tx_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] result;
  logic       tx_full;

  logic       wr_u, wr_s, busy_u, busy_s, done_u, done_s;
  logic [7:0] out_u, out_s;

  always #5 clk = ~clk;

  uart_result_tx_seq #(.N(8), .SIGNED(1'b0), .SEND_EOL(1'b1)) dut_u (
    .clk(clk), .reset(reset), .start(start), .result(result),
    .tx_full(tx_full), .wr_uart(wr_u), .uart_out(out_u),
    .busy(busy_u), .done(done_u)
  );

  uart_result_tx_seq #(.N(8), .SIGNED(1'b1), .SEND_EOL(1'b1)) dut_s (
    .clk(clk), .reset(reset), .start(start), .result(result),
    .tx_full(tx_full), .wr_uart(wr_s), .uart_out(out_s),
    .busy(busy_s), .done(done_s)
  );

  logic [1:0] d_wr, d_busy, d_done;
  logic [7:0] d_out [2];
  assign d_wr     = {wr_s, wr_u};
  assign d_busy   = {busy_s, busy_u};
  assign d_done   = {done_s, done_u};
  assign d_out[0] = out_u;
  assign d_out[1] = out_s;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Model: phase 0 idle, 1 converting, 2 emitting, 3 done pulse.
  int         ph   [2] = '{0, 0};
  int         cnt  [2];
  int         mlen [2];
  int         midx [2];
  logic [7:0] mq   [2][8];

  // Observed write/done history.
  int          wr_cnt [2] = '{0, 0};
  int          dn_cnt [2] = '{0, 0};
  int          wc     [2][1024];
  int          dc     [2][256];
  logic [63:0] log_r  [2] = '{64'd0, 64'd0};

  task automatic chk(input string nm, input int k, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] @cycle %0d: got %0h expected %0h", nm, k, cyc, act, exp);
    end
  endtask

  // Decimal string from plain arithmetic.
  task automatic model_accept(input int k, input logic [7:0] r);
    int v, m, h, t, u, n;
    v = (k == 1 && r[7]) ? int'(r) - 256 : int'(r);
    m = (v < 0) ? -v : v;
    h = m / 100;
    t = (m / 10) % 10;
    u = m % 10;
    n = 0;
    if (v < 0) begin mq[k][n] = 8'h2D; n = n + 1; end
    if (h != 0) begin mq[k][n] = 8'(48 + h); n = n + 1; end
    if (h != 0 || t != 0) begin mq[k][n] = 8'(48 + t); n = n + 1; end
    mq[k][n] = 8'(48 + u); n = n + 1;
    mq[k][n] = 8'd13;      n = n + 1;
    mq[k][n] = 8'd10;      n = n + 1;
    mlen[k] = n;
    midx[k] = 0;
    cnt[k]  = h + t + 2;
    ph[k]   = 1;
  endtask

  // Inputs change only just after posedge, so values seen here are the
  // ones the next posedge will use.
  always @(negedge clk) begin : p_check
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        chk("rst_wr",   k, 64'(d_wr[k]),   64'd0);
        chk("rst_busy", k, 64'(d_busy[k]), 64'd0);
        chk("rst_done", k, 64'(d_done[k]), 64'd0);
        chk("rst_out",  k, 64'(d_out[k]),  64'd0);
        ph[k] = 0;
      end else begin
        chk("busy", k, 64'(d_busy[k]), 64'(ph[k] == 1 || ph[k] == 2));
        chk("done", k, 64'(d_done[k]), 64'(ph[k] == 3));
        chk("wr",   k, 64'(d_wr[k]),   64'(ph[k] == 2 && !tx_full));
        if (ph[k] == 2) chk("char", k, 64'(d_out[k]), 64'(mq[k][midx[k]]));
        case (ph[k])
          0: if (start) model_accept(k, result);
          1: begin
            cnt[k] = cnt[k] - 1;
            if (cnt[k] == 0) ph[k] = 2;
          end
          2: if (!tx_full) begin
            midx[k] = midx[k] + 1;
            if (midx[k] == mlen[k]) ph[k] = 3;
          end
          default: ph[k] = 0;
        endcase
      end
      if (d_wr[k]) begin
        wc[k][wr_cnt[k] % 1024] = cyc;
        log_r[k] = {log_r[k][55:0], d_out[k]};
        wr_cnt[k]++;
      end
      if (d_done[k]) begin
        dc[k][dn_cnt[k] % 256] = cyc;
        dn_cnt[k]++;
      end
    end
  end

  task automatic send(input logic [7:0] r, output int c0);
    @(posedge clk); #1;
    start  = 1'b1;
    result = r;
    c0     = cyc;
    @(posedge clk); #1;
    start  = 1'b0;
    result = 8'($urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy_u || busy_s || done_u || done_s) && n < 200);
    chk("idle_timeout", 0, 64'(n >= 200), 64'd0);
  endtask

  task automatic check_str(input string nm, input int k, input int base,
                           input logic [63:0] exp, input int len);
    logic [63:0] mask;
    chk({nm, "_len"}, k, 64'(wr_cnt[k] - base), 64'(len));
    mask = (len >= 8) ? '1 : ((64'd1 << (8 * len)) - 64'd1);
    chk({nm, "_str"}, k, log_r[k] & mask, exp);
  endtask

  task automatic do_case(input logic [7:0] r, input logic [63:0] eu, input int lu,
                         input logic [63:0] es, input int ls,
                         output int c0, output int bu, output int bs, output int db);
    bu = wr_cnt[0];
    bs = wr_cnt[1];
    db = dn_cnt[0];
    send(r, c0);
    wait_idle();
    check_str("str_u", 0, bu, eu, lu);
    check_str("str_s", 1, bs, es, ls);
  endtask

  initial begin : p_watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : p_stim
    int c0, bu, bs, db, n;
    reset   = 1'b1;
    start   = 1'b0;
    result  = 8'd0;
    tx_full = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy_u", 0, 64'(busy_u), 64'd0);
    chk("reset_out_s",  1, 64'(out_s),  64'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // 255: "255\r\n" from cycle 10, done at 15; signed sees -1.
    do_case(8'd255, {"255", 8'd13, 8'd10}, 5, {"-1", 8'd13, 8'd10}, 4, c0, bu, bs, db);
    chk("t_first_u", 0, 64'(wc[0][bu % 1024] - c0), 64'd10);
    chk("t_last_u",  0, 64'(wc[0][(bu + 4) % 1024] - c0), 64'd14);
    chk("t_done_u",  0, 64'(dc[0][db % 256] - c0), 64'd15);
    chk("t_first_s", 1, 64'(wc[1][bs % 1024] - c0), 64'd3);

    do_case(8'd0, {"0", 8'd13, 8'd10}, 3, {"0", 8'd13, 8'd10}, 3, c0, bu, bs, db);
    chk("t_first_zero", 0, 64'(wc[0][bu % 1024] - c0), 64'd3);
    do_case(8'd7,  {"7", 8'd13, 8'd10},  3, {"7", 8'd13, 8'd10},  3, c0, bu, bs, db);
    do_case(8'd40, {"40", 8'd13, 8'd10}, 4, {"40", 8'd13, 8'd10}, 4, c0, bu, bs, db);
    do_case(8'h80, {"128", 8'd13, 8'd10}, 5, {"-128", 8'd13, 8'd10}, 6, c0, bu, bs, db);
    do_case(8'h7F, {"127", 8'd13, 8'd10}, 5, {"127", 8'd13, 8'd10}, 5, c0, bu, bs, db);

    // 123 with the FIFO full for 4 cycles while '2' is presented (cycles 7-10).
    bu = wr_cnt[0];
    bs = wr_cnt[1];
    send(8'd123, c0);
    repeat (6) @(posedge clk); #1;
    tx_full = 1'b1;
    @(negedge clk);
    chk("stall_out", 0, 64'(out_u), 64'h32);
    chk("stall_wr",  0, 64'(wr_u),  64'd0);
    repeat (4) @(posedge clk); #1;
    tx_full = 1'b0;
    wait_idle();
    check_str("stall_u", 0, bu, {"123", 8'd13, 8'd10}, 5);
    check_str("stall_s", 1, bs, {"123", 8'd13, 8'd10}, 5);
    chk("t_stall_first",  0, 64'(wc[0][bu % 1024] - c0), 64'd6);
    chk("t_stall_second", 0, 64'(wc[0][(bu + 1) % 1024] - c0), 64'd11);

    // Restart while busy and in the done cycle is ignored; next cycle accepts.
    bu = wr_cnt[0];
    send(8'd255, c0);
    repeat (3) @(posedge clk); #1;
    start  = 1'b1;
    result = 8'd9;
    @(posedge clk); #1;
    start  = 1'b0;
    n = 0;
    while (cyc != c0 + 15 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    start  = 1'b1;
    result = 8'd200;
    @(negedge clk);
    chk("done_cycle", 0, 64'(done_u), 64'd1);
    @(posedge clk); #1;
    result = 8'd9;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle();
    check_str("restart_u", 0, bu, {"255", 8'd13, 8'd10, "9", 8'd13, 8'd10}, 8);
    chk("t_restart", 0, 64'(wc[0][(bu + 5) % 1024] - c0), 64'd19);

    // Reset after two characters of "255": output stops, no done.
    bu = wr_cnt[0];
    db = dn_cnt[0];
    send(8'd255, c0);
    n = 0;
    while (wr_cnt[0] < bu + 2 && n < 50) begin
      @(posedge clk);
      n++;
    end
    #1;
    reset = 1'b1;
    @(negedge clk);
    chk("abort_wr",   0, 64'(wr_u),   64'd0);
    chk("abort_busy", 0, 64'(busy_u), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (20) @(negedge clk);
    chk("abort_writes", 0, 64'(wr_cnt[0] - bu), 64'd2);
    chk("abort_nodone", 0, 64'(dn_cnt[0] - db), 64'd0);
    do_case(8'd9, {"9", 8'd13, 8'd10}, 3, {"9", 8'd13, 8'd10}, 3, c0, bu, bs, db);

    // Random traffic: start pulses (often while busy), FIFO back-pressure.
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      start   = ($urandom_range(0, 3) == 0);
      result  = 8'($urandom);
      tx_full = ($urandom_range(0, 4) == 0);
    end
    @(posedge clk); #1;
    start   = 1'b0;
    tx_full = 1'b0;
    wait_idle();
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
